doc_wave_mem_arbiter: RTL and testbench
=======================================

Name: doc_wave_mem_arbiter

Overview:
- Arbitrates the shared 8-bit sound wave RAM between two requesters: the doc5503 wave-fetch port and the host/GLU sound-RAM access path.
- Sits between doc5503 (wave_rd_o, wave_address_o, wave_data_ready_i, wave_data_i) and the single-port wave memory controller.
- DOC fetches have priority; a starvation guard bounds host wait time.
- Host writes load wave tables; host reads are for debug/readback.

Parameters:
- ADDR_WIDTH, 16, wave RAM address width
- HOST_MAX_WAIT, 4, consecutive DOC grants allowed while host pending before host is forced to win (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- doc_rd_i  in  1  single-cycle DOC fetch strobe
- doc_addr_i  in  ADDR_WIDTH  DOC fetch address, valid with doc_rd_i
- doc_data_o  out  8  fetched wave byte
- doc_ready_o  out  1  one-cycle pulse, doc_data_o valid
- host_req_i  in  1  host request level, held until host_ack_o
- host_we_i  in  1  1=write, 0=read, held with host_req_i
- host_addr_i  in  ADDR_WIDTH  host address
- host_wdata_i  in  8  host write data
- host_rdata_o  out  8  host read data
- host_ack_o  out  1  one-cycle completion pulse
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  8  memory write data
- mem_rdata_i  in  8  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle access-complete strobe
- doc_overrun_o  out  1  sticky: DOC strobe lost

Behaviour:
- Reset: all outputs 0; state IDLE; doc pending cleared; streak counter 0. Reset mid-access drops mem_req_o immediately, discards pending work, and issues no ack. A mem_ack_i after reset is ignored.
- DOC capture: doc_rd_i latches doc_addr_i into a one-deep pending register.
  - If a strobe arrives while pending is set and not yet granted, the new address overwrites the old one and doc_overrun_o is set.
  - A strobe during an in-flight DOC access goes into pending without overrun.
- States: IDLE, DOC_ACC, HOST_ACC.
- IDLE, evaluated each edge:
  - doc_req = pending | doc_rd_i
  - host_eligible = host_req_i & ~host_ack_o
  - Host wins if host_eligible and (~doc_req or streak == HOST_MAX_WAIT).
  - Otherwise DOC wins if doc_req.
  - On a grant, register mem_req_o=1 and mem_addr/we/wdata, then enter *_ACC. A DOC grant clears pending.
  - doc_rd_i sampled at edge t gives mem_req_o high from edge t (same edge, bypassing pending).
- DOC_ACC / HOST_ACC:
  - Hold mem_* stable until mem_ack_i is sampled.
  - On that edge: drop mem_req_o and go to IDLE.
  - DOC_ACC: doc_data_o <= mem_rdata_i, doc_ready_o pulses the next cycle.
  - HOST_ACC: host_rdata_o <= mem_rdata_i on reads (unchanged on writes), host_ack_o pulses the next cycle.
- Minimum one IDLE cycle between accesses.
- doc_data_o / host_rdata_o hold their value until the next completion of the same kind.
- Streak counter: +1 on a DOC grant while host_eligible; cleared on a host grant or when host_req_i is low in IDLE; saturates at HOST_MAX_WAIT.
- host_req_i is ignored in the cycle host_ack_o is high, so the host has one cycle to drop it.
- mem_ack_i in IDLE is ignored.

Decomposition:
- Package doc_mem_pkg:
  - arb_state_t enum (IDLE, DOC_ACC, HOST_ACC)
  - DOC_DATA_W=8
  - default ADDR_WIDTH constant
- Single module, no sub-module; pending latch and arbiter are inline.

Test Plan:
- DOC-only read, memory acks 2 cycles after mem_req_o, mem_rdata_i=0x5A for doc_addr_i=0x0042 -> mem_addr_o=0x0042, mem_we_o=0, one doc_ready_o pulse with doc_data_o=0x5A, doc_overrun_o=0.
- Host write 0x0100=0xC3, then host read 0x0100, memory model returns the stored byte -> two host_ack_o pulses; second read gives host_rdata_o=0xC3; host_req held through ack never causes a third access.
- doc_rd_i and host_req_i asserted at the same edge -> DOC granted first, host granted on the following IDLE; exactly one ack pulse each.
- doc_rd_i every 3 cycles, memory latency 4, host_req_i held, HOST_MAX_WAIT=4 -> host granted after exactly 4 DOC grants; doc_overrun_o sets on the first overwritten strobe.
- reset_n low during HOST_ACC before mem_ack_i -> mem_req_o=0 and host_ack_o=0 next cycle; the late mem_ack_i produces no ack; all outputs 0.

Source files
------------

// File: rtl/doc_mem_pkg.sv
// Shared types and constants for the DOC wave RAM arbiter.
// Arbiter states plus data/address width defaults.
package doc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DOC_ACC,
    HOST_ACC
  } arb_state_t;

  localparam int DOC_DATA_W     = 8;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int STREAK_W       = 4;

endpackage

// File: rtl/doc_wave_mem_arbiter.sv
// Shares the single-port wave RAM between DOC fetches and host access.
// DOC has priority; a grant streak counter bounds host wait time.
module doc_wave_mem_arbiter
  import doc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  doc_rd_i,
  input  logic [ADDR_WIDTH-1:0] doc_addr_i,
  output logic [DOC_DATA_W-1:0] doc_data_o,
  output logic                  doc_ready_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DOC_DATA_W-1:0] host_wdata_i,
  output logic [DOC_DATA_W-1:0] host_rdata_o,
  output logic                  host_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DOC_DATA_W-1:0] mem_wdata_o,
  input  logic [DOC_DATA_W-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  doc_overrun_o
);

  localparam logic [STREAK_W-1:0] MAX_W =
    STREAK_W'(HOST_MAX_WAIT);

  arb_state_t            state;
  logic                  pend_valid;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [STREAK_W-1:0]   streak;

  logic                  doc_req;
  logic [ADDR_WIDTH-1:0] doc_sel_addr;
  logic                  host_elig;
  logic                  host_win;
  logic                  doc_win;

  // A fresh strobe bypasses (and replaces) the pending address.
  assign doc_req      = pend_valid | doc_rd_i;
  assign doc_sel_addr = doc_rd_i ? doc_addr_i : pend_addr;
  assign host_elig    = host_req_i & ~host_ack_o;
  assign host_win     = host_elig &
                        (~doc_req | (streak == MAX_W));
  assign doc_win      = doc_req & ~host_win;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      streak        <= '0;
      doc_data_o    <= '0;
      doc_ready_o   <= 1'b0;
      host_rdata_o  <= '0;
      host_ack_o    <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      doc_overrun_o <= 1'b0;
    end else begin
      doc_ready_o <= 1'b0;
      host_ack_o  <= 1'b0;

      if (doc_rd_i) begin
        pend_valid <= 1'b1;
        pend_addr  <= doc_addr_i;
        if (pend_valid) begin
          doc_overrun_o <= 1'b1;
        end
      end

      unique case (state)
        IDLE: begin
          unique case (1'b1)
            host_win: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= host_we_i;
              mem_addr_o  <= host_addr_i;
              mem_wdata_o <= host_wdata_i;
              streak      <= '0;
              state       <= HOST_ACC;
            end
            doc_win: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b0;
              mem_addr_o  <= doc_sel_addr;
              mem_wdata_o <= '0;
              pend_valid  <= 1'b0;
              state       <= DOC_ACC;
              if (host_elig) begin
                if (streak != MAX_W) begin
                  streak <= streak + 1'b1;
                end
              end else if (!host_req_i) begin
                streak <= '0;
              end
            end
            default: begin
              if (!host_req_i) begin
                streak <= '0;
              end
            end
          endcase
        end
        DOC_ACC: begin
          if (mem_ack_i) begin
            mem_req_o   <= 1'b0;
            doc_data_o  <= mem_rdata_i;
            doc_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        HOST_ACC: begin
          if (mem_ack_i) begin
            mem_req_o  <= 1'b0;
            host_ack_o <= 1'b1;
            state      <= IDLE;
            if (!mem_we_o) begin
              host_rdata_o <= mem_rdata_i;
            end
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_doc_wave_mem_arbiter.sv
// Directed and randomized bench for doc_wave_mem_arbiter.
// A latency-programmable memory model answers the arbiter's requests.
module tb_doc_wave_mem_arbiter;

  localparam int AW   = 16;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          doc_rd_i = 1'b0;
  logic [AW-1:0] doc_addr_i = '0;
  logic [7:0]    doc_data_o;
  logic          doc_ready_o;
  logic          host_req_i = 1'b0;
  logic          host_we_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [7:0]    host_wdata_i = '0;
  logic [7:0]    host_rdata_o;
  logic          host_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          doc_overrun_o;

  doc_wave_mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .doc_rd_i     (doc_rd_i),
    .doc_addr_i   (doc_addr_i),
    .doc_data_o   (doc_data_o),
    .doc_ready_o  (doc_ready_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_rdata_o (host_rdata_o),
    .host_ack_o   (host_ack_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .doc_overrun_o(doc_overrun_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h18;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_doc(input int bound,
                          output bit ok, output int cyc_n);
    ok = 0;
    cyc_n = 0;
    while (!ok && cyc_n < bound) begin
      tick(1);
      cyc_n++;
      if (doc_ready_o) ok = 1;
    end
  endtask

  task automatic wait_host(input int bound,
                           output bit ok, output int cyc_n);
    ok = 0;
    cyc_n = 0;
    while (!ok && cyc_n < bound) begin
      tick(1);
      cyc_n++;
      if (host_ack_o) ok = 1;
    end
  endtask

  // Memory model: acks after a fixed or random latency.
  logic [7:0] mem [0:65535];
  int   fixed_lat = 2;
  int   cur_lat = 1;
  int   acnt = 0;
  bit   mem_en = 1;
  logic manual_ack = 1'b0;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    forever begin
      @(negedge clk);
      #1;
      if (!mem_en) begin
        mem_ack_i = manual_ack;
        acnt = 0;
      end else if (mem_req_o && reset_n) begin
        if (acnt == 0)
          cur_lat = (fixed_lat > 0) ? fixed_lat
                                    : int'($urandom_range(1, 5));
        acnt++;
        if (acnt == cur_lat) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = mem[mem_addr_o];
          if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
        end else begin
          mem_ack_i = 1'b0;
        end
      end else begin
        mem_ack_i = 1'b0;
        acnt = 0;
        mem_rdata_i = 8'($urandom);
      end
    end
  end

  // Bus monitor: grant log, pulse counts, request stability.
  int          cyc = 0;
  int          n_grant = 0;
  int          n_doc_rdy = 0;
  int          n_host_ack = 0;
  logic        prev_req = 1'b0;
  logic [24:0] hold_bus = '0;
  logic [15:0] grant_q[$];
  int          grant_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (mem_req_o && !prev_req) begin
        grant_q.push_back(mem_addr_o);
        grant_cyc.push_back(cyc);
        n_grant++;
        hold_bus = {mem_we_o, mem_wdata_o, mem_addr_o};
      end else if (mem_req_o) begin
        chk("mem_hold",
            {7'd0, mem_we_o, mem_wdata_o, mem_addr_o},
            {7'd0, hold_bus});
      end
      n_doc_rdy += int'(doc_ready_o);
      n_host_ack += int'(host_ack_o);
      prev_req = mem_req_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit          ok;
  int          c;
  int          g0;
  int          a0;
  int          d0;
  int          hseen;
  logic [15:0] exp4 [5];
  logic [15:0] doc_q[$];
  logic [7:0]  href [logic [15:0]];

  initial begin
    // Reset values
    reset_n = 1'b0;
    tick(3);
    chk("rst_ctl",
        {mem_req_o, mem_we_o, doc_ready_o,
         host_ack_o, doc_overrun_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data",
        {doc_data_o, host_rdata_o, mem_wdata_o}, 0);
    reset_n = 1'b1;
    tick(1);

    // DOC-only read
    fixed_lat = 2;
    doc_addr_i = 16'h0042;
    doc_rd_i = 1'b1;
    tick(1);
    doc_rd_i = 1'b0;
    chk("t1_req", mem_req_o, 1);
    chk("t1_addr", mem_addr_o, 16'h0042);
    chk("t1_we", mem_we_o, 0);
    wait_doc(20, ok, c);
    chk("t1_ready_seen", ok, 1);
    chk("t1_latency", c, 2);
    chk("t1_data", doc_data_o, 8'h5A);
    chk("t1_overrun", doc_overrun_o, 0);
    tick(1);
    chk("t1_one_pulse", doc_ready_o, 0);
    tick(2);

    // Host write then read back, req held through ack
    g0 = n_grant;
    a0 = n_host_ack;
    host_we_i = 1'b1;
    host_addr_i = 16'h0100;
    host_wdata_i = 8'hC3;
    host_req_i = 1'b1;
    wait_host(20, ok, c);
    chk("t2_wr_ack", ok, 1);
    tick(1);
    host_req_i = 1'b0;
    tick(1);
    host_we_i = 1'b0;
    host_req_i = 1'b1;
    wait_host(20, ok, c);
    chk("t2_rd_ack", ok, 1);
    chk("t2_rdata", host_rdata_o, 8'hC3);
    tick(1);
    host_req_i = 1'b0;
    tick(6);
    chk("t2_accesses", n_grant - g0, 2);
    chk("t2_acks", n_host_ack - a0, 2);

    // Simultaneous DOC and host: DOC first, host next idle
    g0 = n_grant;
    a0 = n_host_ack;
    d0 = n_doc_rdy;
    grant_q.delete();
    grant_cyc.delete();
    doc_addr_i = 16'h0010;
    doc_rd_i = 1'b1;
    host_we_i = 1'b0;
    host_addr_i = 16'h0200;
    host_req_i = 1'b1;
    tick(1);
    doc_rd_i = 1'b0;
    chk("t3_doc_first", mem_addr_o, 16'h0010);
    wait_host(30, ok, c);
    host_req_i = 1'b0;
    chk("t3_host_ack", ok, 1);
    chk("t3_host_rdata", host_rdata_o, 8'h1A);
    chk("t3_doc_data", doc_data_o, 8'h08);
    tick(4);
    chk("t3_accesses", n_grant - g0, 2);
    chk("t3_host_pulses", n_host_ack - a0, 1);
    chk("t3_doc_pulses", n_doc_rdy - d0, 1);
    chk("t3_qsize", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("t3_host_addr", grant_q[1], 16'h0200);
      chk("t3_gap", grant_cyc[1] - grant_cyc[0], 3);
    end

    // Starvation guard: DOC every 3 cycles, latency 4
    fixed_lat = 4;
    grant_q.delete();
    hseen = 0;
    host_we_i = 1'b0;
    host_addr_i = 16'h0300;
    for (int i = 0; i < 30; i++) begin
      doc_rd_i = (i % 3 == 0);
      doc_addr_i = 16'h1000 + 16'(i);
      if (i == 0) host_req_i = 1'b1;
      else if (host_ack_o) host_req_i = 1'b0;
      tick(1);
      if (host_ack_o) hseen++;
      if (i == 8) chk("t4_ovr_clear", doc_overrun_o, 0);
      if (i == 9) chk("t4_ovr_set", doc_overrun_o, 1);
    end
    doc_rd_i = 1'b0;
    host_req_i = 1'b0;
    tick(15);
    chk("t4_host_acks", hseen, 1);
    exp4 = '{16'h1000, 16'h1003, 16'h1009,
             16'h100F, 16'h0300};
    chk("t4_qsize_ok", grant_q.size() >= 5, 1);
    if (grant_q.size() >= 5) begin
      for (int j = 0; j < 5; j++)
        chk($sformatf("t4_grant%0d", j),
            grant_q[j], exp4[j]);
    end

    // Reset during host access, then a late ack
    mem_en = 0;
    manual_ack = 1'b0;
    a0 = n_host_ack;
    host_we_i = 1'b1;
    host_addr_i = 16'h0400;
    host_wdata_i = 8'h99;
    host_req_i = 1'b1;
    tick(1);
    chk("t5_req", mem_req_o, 1);
    chk("t5_addr", mem_addr_o, 16'h0400);
    tick(1);
    reset_n = 1'b0;
    host_req_i = 1'b0;
    tick(1);
    chk("t5_req_drop", mem_req_o, 0);
    chk("t5_no_ack", host_ack_o, 0);
    chk("t5_ctl_zero",
        {mem_we_o, doc_ready_o, doc_overrun_o}, 0);
    chk("t5_data_zero",
        {doc_data_o, host_rdata_o, mem_wdata_o}, 0);
    chk("t5_addr_zero", mem_addr_o, 0);
    reset_n = 1'b1;
    manual_ack = 1'b1;
    tick(1);
    manual_ack = 1'b0;
    chk("t5_late_req", mem_req_o, 0);
    tick(3);
    chk("t5_late_ack", n_host_ack - a0, 0);
    mem_en = 1;
    tick(2);

    // Random traffic against the reference model
    fixed_lat = 0;
    a0 = n_host_ack;
    d0 = n_doc_rdy;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          logic [15:0] da;
          da = 16'h8000 | 16'($urandom_range(0, 32767));
          doc_q.push_back(da);
          doc_addr_i = da;
          doc_rd_i = 1'b1;
          tick(1);
          doc_rd_i = 1'b0;
          tick($urandom_range(16, 24));
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          logic [15:0] ha;
          logic [7:0]  hd;
          logic [7:0]  he;
          bit          hw;
          bit          hok;
          int          hc;
          ha = 16'($urandom_range(0, 15));
          hw = 1'($urandom_range(0, 1));
          hd = 8'($urandom);
          he = href.exists(ha) ? href[ha] : pat(ha);
          host_addr_i = ha;
          host_we_i = hw;
          host_wdata_i = hd;
          host_req_i = 1'b1;
          wait_host(100, hok, hc);
          host_req_i = 1'b0;
          chk("rnd_host_ack", hok, 1);
          if (hw) href[ha] = hd;
          else chk("rnd_host_rdata", host_rdata_o, he);
          tick($urandom_range(0, 3));
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          bit dok;
          int dc;
          wait_doc(200, dok, dc);
          chk("rnd_doc_ready", dok, 1);
          chk("rnd_doc_q", doc_q.size() != 0, 1);
          if (dok && doc_q.size() != 0)
            chk("rnd_doc_data", doc_data_o,
                pat(doc_q.pop_front()));
        end
      end
    join
    tick(5);
    chk("rnd_overrun", doc_overrun_o, 0);
    chk("rnd_doc_cnt", n_doc_rdy - d0, 12);
    chk("rnd_host_cnt", n_host_ack - a0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
